// File: rtl/vga_fb_fetch_pkg.sv
// vga_pkg: fetch FSM states, framebuffer word geometry and the frame-length helper.
// Also supplies a default line/frame length width when `VGA_VB_WIDTH is not set by the build.
`ifndef VGA_VB_WIDTH
`define VGA_VB_WIDTH 12
`endif
package vga_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DONE, FLUSH} fetch_state_e;
  localparam int VGA_FB_WORD_BYTES   = 8;
  localparam int VGA_FB_PIX_PER_WORD = 4;
  localparam int VB_W  = `VGA_VB_WIDTH;
  localparam int CNT_W = 2 * VB_W;
  // Words per frame, rounding a partial final word up.
  function automatic logic [CNT_W-1:0] fb_nwords(input logic [VB_W-1:0] h, input logic [VB_W-1:0] v);
    logic [CNT_W:0] pix;
    pix = (CNT_W+1)'(h) * (CNT_W+1)'(v) + (CNT_W+1)'(VGA_FB_PIX_PER_WORD - 1);
    return CNT_W'(pix / (CNT_W+1)'(VGA_FB_PIX_PER_WORD));
  endfunction
endpackage

// File: rtl/vga_fb_fetch_if.sv
// vga_fb_fetch_if: memory read port plus pixel stream between the fetch controller and its neighbours.
//   master (fetch side): drives mem_req/mem_addr/pixel_valid/pixel_data, sees mem_gnt/mem_rvalid/mem_rdata/pixel_ready
//   slave  (memory + VGA core side): the mirror image
interface vga_fb_fetch_if #(parameter int ADDR_WIDTH = 32);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [63:0]           mem_rdata;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [63:0]           pixel_data;
  modport master (output mem_req, mem_addr, pixel_valid, pixel_data,
                  input  mem_gnt, mem_rvalid, mem_rdata, pixel_ready);
  modport slave  (input  mem_req, mem_addr, pixel_valid, pixel_data,
                  output mem_gnt, mem_rvalid, mem_rdata, pixel_ready);
endinterface

// File: rtl/vga_fb_fetch_fifo.sv
// vga_fb_fifo: synchronous DEPTH x WIDTH FIFO with flush; head is visible the cycle after a push.
//   clk_i/rst_n_i clock and async active-low reset; push_i/data_i write; pop_i read;
//   flush_i empties it; data_o head word; count_o occupancy; empty_o/full_o status.
module vga_fb_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  always_comb begin
    do_push = push_i && !flush_i;
    do_pop  = pop_i && !empty_o && !flush_i;
    wr_d    = flush_i ? '0 : wr_q + PW'(do_push);
    rd_d    = flush_i ? '0 : rd_q + PW'(do_pop);
    cnt_d   = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: framebuffer fetch controller; reads 64-bit pixel words from memory into a FIFO for the VGA core.
//   clk_i, rst_n_i (async active-low); en_i enable; test_i test-pattern mode (no fetching);
//   base_addr_i frame base; hvlen_i/vvlen_i visible size; vend_i frame-end pulse;
//   bus (vga_fb_fetch_if.master) memory read port + pixel stream; underflow_o sticky underflow; busy_o not idle.
//   Define VGA_FB_DBLBUF_EN to add base_addr1_i and buf_sel_o (double-buffered frame base).
module vga_fb_fetch
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTST  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic                     test_i,
  input  logic [ADDR_WIDTH-1:0]    base_addr_i,
`ifdef VGA_FB_DBLBUF_EN
  input  logic [ADDR_WIDTH-1:0]    base_addr1_i,
  output logic                     buf_sel_o,
`endif
  input  logic [`VGA_VB_WIDTH-1:0] hvlen_i,
  input  logic [`VGA_VB_WIDTH-1:0] vvlen_i,
  input  logic                     vend_i,
  vga_fb_fetch_if.master           bus,
  output logic                     underflow_o,
  output logic                     busy_o
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base;
  logic [CNT_W-1:0]      nwords_q, nwords_d, req_cnt_q, req_cnt_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  underflow_q, underflow_d;
  logic [FW-1:0]         fifo_cnt;
  logic [63:0]           fifo_head;
  logic                  fifo_empty, fifo_full;
  logic                  credit, req, fire, push, pop, flush, pix_valid, stop, go, load, drained;
`ifdef VGA_FB_DBLBUF_EN
  logic buf_sel_q, buf_sel_d;
  assign buf_sel_d = buf_sel_q ^ (vend_i && en_i);
  assign buf_sel_o = buf_sel_q;
  assign base      = buf_sel_q ? base_addr1_i : base_addr_i;
`else
  assign base = base_addr_i;
`endif
  always_comb begin
    // In-flight reads already own FIFO slots, so a request is only raised when its data is sure to fit.
    credit    = 32'(fifo_cnt) + 32'(outst_q) < 32'(FIFO_DEPTH);
    req       = state_q == FETCH && req_cnt_q < nwords_q && credit && outst_q < OW'(MAX_OUTST);
    fire      = req && bus.mem_gnt;
    push      = bus.mem_rvalid && (state_q == FETCH || state_q == DONE);
    flush     = state_q == FLUSH;
    pix_valid = !fifo_empty && !flush;
    pop       = pix_valid && bus.pixel_ready;
    stop      = vend_i || !en_i || test_i;
    go        = en_i && !test_i;
    drained   = state_q == FLUSH && outst_q == '0;
    load      = go && (state_q == IDLE || drained);
    state_d   = load ? FETCH :
                drained ? IDLE :
                ((state_q == FETCH || state_q == DONE) && stop) ? FLUSH :
                (state_q == FETCH && req_cnt_q == nwords_q) ? DONE : state_q;
    addr_d      = load ? base & ~ADDR_WIDTH'(VGA_FB_WORD_BYTES - 1) :
                  fire ? addr_q + ADDR_WIDTH'(VGA_FB_WORD_BYTES) : addr_q;
    nwords_d    = load ? fb_nwords(hvlen_i, vvlen_i) : nwords_q;
    req_cnt_d   = load ? '0 : req_cnt_q + CNT_W'(fire);
    // Reads granted on the way into FLUSH still return, so outst keeps tracking in every state.
    outst_d     = outst_q + OW'(fire) - OW'(bus.mem_rvalid);
    underflow_d = en_i && (underflow_q || (state_q == FETCH && bus.pixel_ready && fifo_empty));
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      nwords_q    <= '0;
      req_cnt_q   <= '0;
      outst_q     <= '0;
      underflow_q <= 1'b0;
`ifdef VGA_FB_DBLBUF_EN
      buf_sel_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nwords_q    <= nwords_d;
      req_cnt_q   <= req_cnt_d;
      outst_q     <= outst_d;
      underflow_q <= underflow_d;
`ifdef VGA_FB_DBLBUF_EN
      buf_sel_q   <= buf_sel_d;
`endif
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_n_i) assert (!(push && fifo_full && !pop));
  end
  vga_fb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (bus.mem_rdata),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
  assign bus.mem_req     = req;
  assign bus.mem_addr    = addr_q;
  assign bus.pixel_valid = pix_valid;
  assign bus.pixel_data  = pix_valid ? fifo_head : '0;
  assign underflow_o     = underflow_q;
  assign busy_o          = state_q != IDLE;
endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch: directed bench for vga_fb_fetch with a 2-cycle-latency in-order memory model.
module tb_vga_fb_fetch;
  logic        clk = 1'b0;
  logic        rst_n, en, test, vend, gnt, rv_en, ready;
  logic [31:0] base, base1;
  logic [11:0] hv, vv;
  logic        underflow, busy;
  logic        buf_sel;
  int          checks = 0, passes = 0, cyc = 0;
  logic [31:0] req_log[$];
  typedef struct {logic [31:0] a; int due;} rd_t;
  rd_t         q[$];

  vga_fb_fetch_if #(.ADDR_WIDTH(32)) bus ();
  assign bus.mem_gnt     = gnt;
  assign bus.pixel_ready = ready;

  vga_fb_fetch #(.FIFO_DEPTH(4), .MAX_OUTST(4), .ADDR_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .test_i      (test),
    .base_addr_i (base),
`ifdef VGA_FB_DBLBUF_EN
    .base_addr1_i(base1),
    .buf_sel_o   (buf_sel),
`endif
    .hvlen_i     (hv),
    .vvlen_i     (vv),
    .vend_i      (vend),
    .bus         (bus),
    .underflow_o (underflow),
    .busy_o      (busy)
  );
`ifndef VGA_FB_DBLBUF_EN
  assign buf_sel = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [31:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata  <= '0;
    end else begin
      if (bus.mem_rvalid) void'(q.pop_front());
      if (bus.mem_req && bus.mem_gnt) begin
        q.push_back('{bus.mem_addr, cyc + 2});
        req_log.push_back(bus.mem_addr);
      end
      cyc++;
      bus.mem_rvalid <= rv_en && q.size() > 0 && q[0].due <= cyc;
      bus.mem_rdata  <= q.size() > 0 ? word(q[0].a) : 64'd0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_vend();
    vend = 1'b1;
    @(negedge clk);
    vend = 1'b0;
  endtask

  initial begin
    rst_n = 0; en = 0; test = 0; vend = 0; gnt = 0; rv_en = 1; ready = 0;
    base = 32'h1000; base1 = 32'h1000; hv = 8; vv = 2;
    step(2);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_pvalid", bus.pixel_valid, 0);
    chk("rst_pdata", bus.pixel_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bufsel", buf_sel, 0);
    rst_n = 1; gnt = 1;
    step(1);
    en = 1;
    step(20);
    chk("f1_nreq", 64'(req_log.size()), 4);
    chk("f1_a0", req_log[0], 32'h1000);
    chk("f1_a1", req_log[1], 32'h1008);
    chk("f1_a2", req_log[2], 32'h1010);
    chk("f1_a3", req_log[3], 32'h1018);
    chk("f1_done_req", bus.mem_req, 0);
    chk("f1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("f1_pvalid", bus.pixel_valid, 1);
      chk("f1_pdata", bus.pixel_data, word(32'h1000 + 32'(8 * i)));
      ready = 1;
      @(negedge clk);
      ready = 0;
    end
    chk("f1_empty", bus.pixel_valid, 0);
    ready = 1;
    @(negedge clk);
    ready = 0;
    step(1);
    chk("done_no_underflow", underflow, 0);
    // credit limit: core never ready, 8-word frame, 4-deep FIFO
    req_log.delete();
    vv = 4;
    pulse_vend();
    step(20);
    chk("cr_nreq", 64'(req_log.size()), 4);
    chk("cr_last", req_log[3], 32'h1018);
    chk("cr_req_off", bus.mem_req, 0);
    chk("cr_head", bus.pixel_data, word(32'h1000));
    ready = 1;
    @(negedge clk);
    ready = 0;
    step(10);
    chk("cr_one_more", 64'(req_log.size()), 5);
    chk("cr_new_addr", req_log[4], 32'h1020);
    chk("cr_req_off2", bus.mem_req, 0);
    // frame end with two reads in flight
    gnt = 0; rv_en = 0;
    pulse_vend();
    req_log.delete();
    step(2);
    chk("rs_pvalid", bus.pixel_valid, 0);
    chk("rs_req", bus.mem_req, 1);
    chk("rs_addr", bus.mem_addr, 32'h1000);
    gnt = 1;
    step(2);
    gnt = 0;
    chk("os_nreq", 64'(req_log.size()), 2);
    chk("os_held_req", bus.mem_req, 1);
    chk("os_held_addr", bus.mem_addr, 32'h1010);
    pulse_vend();
    chk("fl_req", bus.mem_req, 0);
    chk("fl_busy", busy, 1);
    step(3);
    chk("fl_wait_req", bus.mem_req, 0);
    chk("fl_wait_busy", busy, 1);
    rv_en = 1;
    step(8);
    chk("fl_dropped", bus.pixel_valid, 0);
    chk("fl_restart_req", bus.mem_req, 1);
    chk("fl_restart_addr", bus.mem_addr, 32'h1000);
    chk("fl_no_req", 64'(req_log.size()), 2);
    gnt = 1;
    for (int i = 0; i < 20 && !bus.pixel_valid; i++) @(negedge clk);
    chk("fl_first_push", bus.pixel_valid, 1);
    chk("fl_first_data", bus.pixel_data, word(32'h1000));
    // underflow
    gnt = 0;
    step(10);
    chk("uf_clear", underflow, 0);
    ready = 1;
    step(10);
    ready = 0;
    chk("uf_set", underflow, 1);
    pulse_vend();
    step(3);
    chk("uf_hold_vend", underflow, 1);
    en = 0;
    step(1);
    chk("uf_cleared_en", underflow, 0);
    step(3);
    chk("dis_idle", busy, 0);
    // test-pattern mode
    req_log.delete();
    gnt = 1; vv = 2; en = 1;
    step(3);
    test = 1;
    step(1);
    chk("tp_req", bus.mem_req, 0);
    chk("tp_busy_flush", busy, 1);
    step(10);
    chk("tp_idle", busy, 0);
    chk("tp_req2", bus.mem_req, 0);
    chk("tp_pvalid", bus.pixel_valid, 0);
    // empty frame
    req_log.delete();
    hv = 0; test = 0;
    step(10);
    chk("nz_nreq", 64'(req_log.size()), 0);
    chk("nz_busy", busy, 1);
    chk("nz_req", bus.mem_req, 0);
    // address wrap with an unaligned base
    base = 32'hFFFF_FFFD; base1 = 32'hFFFF_FFFD; hv = 8; vv = 1;
    req_log.delete();
    pulse_vend();
    step(10);
    chk("wr_nreq", 64'(req_log.size()), 2);
    chk("wr_a0", req_log[0], 32'hFFFF_FFF8);
    chk("wr_a1", req_log[1], 32'h0000_0000);
`ifdef VGA_FB_DBLBUF_EN
    en = 0; rst_n = 0;
    step(2);
    chk("db_rst_sel", buf_sel, 0);
    rst_n = 1; base = 32'h1000; base1 = 32'h8000; vv = 2;
    req_log.delete();
    en = 1;
    step(15);
    chk("db_f1_sel", buf_sel, 0);
    chk("db_f1_a0", req_log[0], 32'h1000);
    req_log.delete();
    pulse_vend();
    step(15);
    chk("db_f2_sel", buf_sel, 1);
    chk("db_f2_a0", req_log[0], 32'h8000);
    chk("db_f2_a3", req_log[3], 32'h8018);
    req_log.delete();
    pulse_vend();
    step(15);
    chk("db_f3_sel", buf_sel, 0);
    chk("db_f3_a0", req_log[0], 32'h1000);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
